// File: rtl/row_window_buffer_if.sv
// Handshake bundle between the line-buffer read port, the window buffer and the PE array.
// The slave modport is the window buffer's view; the master modport is the view of its environment.
interface row_window_buffer_if #(
  parameter int unsigned ROWS    = 3,
  parameter int unsigned PIX_IN  = 32,
  parameter int unsigned PIX_OUT = 32,
  parameter int unsigned DW      = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_first;
  logic                         in_last;
  logic [7:0]                   in_start_idx;
  logic [7:0]                   in_end_idx;
  logic [ROWS*PIX_IN*DW-1:0]    in_pixels;
  logic                         win_valid;
  logic                         win_ready;
  logic [ROWS*PIX_OUT*DW-1:0]   win_pixels;
  logic [3:0]                   win_step;
  logic                         win_last;

  modport master (
    output in_valid, in_first, in_last, in_start_idx, in_end_idx, in_pixels, win_ready,
    input  in_ready, win_valid, win_pixels, win_step, win_last
  );

  modport slave (
    input  in_valid, in_first, in_last, in_start_idx, in_end_idx, in_pixels, win_ready,
    output in_ready, win_valid, win_pixels, win_step, win_last
  );
endinterface

// File: rtl/row_window_buffer.sv
// Multi-row pixel window buffer: fills ROWS x DEPTH registers from chunk beats, then
// presents a PIX_OUT-wide window for cfg_k steps, shifting by cfg_d between steps.
module row_window_buffer #(
  parameter int unsigned ROWS    = 3,
  parameter int unsigned DEPTH   = 70,
  parameter int unsigned PIX_IN  = 32,
  parameter int unsigned PIX_OUT = 32,
  parameter int unsigned DW      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             cfg_k,
  input  logic [2:0]             cfg_d,
  input  logic [1:0]             slab_num,
  input  logic [ROWS*2*DW-1:0]   slab_in,
  output logic                   busy,
  row_window_buffer_if.slave     bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int Depth = int'(DEPTH);

  typedef enum logic [1:0] {StIdle, StFill, StWin} state_e;

  state_e         state_q, state_d;
  logic [3:0]     step_q, step_d;
  logic [3:0]     k_q, k_d;
  logic [2:0]     d_q, d_d;
  logic [DW-1:0]  mem_q [ROWS][DEPTH];
  logic [DW-1:0]  mem_d [ROWS][DEPTH];

  logic           accept;
  logic           first_eff;
  logic           step_last;
  logic [1:0]     slab_eff;

  assign bus.in_ready  = (state_q != StWin);
  assign bus.win_valid = (state_q == StWin);
  assign bus.win_step  = step_q;
  assign step_last     = (step_q == k_q - 4'd1);
  assign bus.win_last  = (state_q == StWin) && step_last;
  assign busy          = (state_q != StIdle);

  assign accept    = bus.in_valid && bus.in_ready;
  // A beat landing in IDLE always opens a new slice, even without in_first.
  assign first_eff = bus.in_first || (state_q == StIdle);
  assign slab_eff  = (slab_num == 2'd3) ? 2'd2 : slab_num;

  always_comb begin
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int p = 0; p < int'(PIX_OUT); p++) begin
        bus.win_pixels[(r*int'(PIX_OUT)+p)*int'(DW) +: DW] = mem_q[r][p];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    k_d     = k_q;
    d_d     = d_q;
    mem_d   = mem_q;

    unique case (state_q)
      StIdle, StFill: begin
        if (accept) begin
          state_d = bus.in_last ? StWin : StFill;
          if (first_eff) begin
            k_d    = (cfg_k == 4'd0) ? 4'd1 : cfg_k;
            d_d    = (cfg_d == 3'd0) ? 3'd1 : cfg_d;
            step_d = 4'd0;
            for (int r = 0; r < int'(ROWS); r++) begin
              for (int p = 0; p < Depth; p++) mem_d[r][p] = '0;
              for (int p = 0; p < 2; p++) begin
                if (p < int'(slab_eff)) mem_d[r][p] = slab_in[(r*2+p)*int'(DW) +: DW];
              end
            end
          end
          // Beat writes land last so they override both clear and slab.
          for (int j = 0; j < int'(PIX_IN); j++) begin
            int pos;
            pos = int'(bus.in_start_idx) + j;
            if (pos <= int'(bus.in_end_idx) && pos < Depth) begin
              for (int r = 0; r < int'(ROWS); r++) begin
                mem_d[r][AW'(pos)] = bus.in_pixels[(r*int'(PIX_IN)+j)*int'(DW) +: DW];
              end
            end
          end
        end
      end
      StWin: begin
        if (bus.win_ready) begin
          if (step_last) begin
            state_d = StIdle;
            step_d  = 4'd0;
          end else begin
            step_d = step_q + 4'd1;
            for (int r = 0; r < int'(ROWS); r++) begin
              for (int p = 0; p < Depth; p++) begin
                int src;
                src = p + int'(d_q);
                mem_d[r][p] = (src < Depth) ? mem_q[r][AW'(src)] : '0;
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      step_q  <= 4'd0;
      k_q     <= 4'd1;
      d_q     <= 3'd1;
      for (int r = 0; r < int'(ROWS); r++) begin
        for (int p = 0; p < Depth; p++) mem_q[r][p] <= '0;
      end
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      k_q     <= k_d;
      d_q     <= d_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_row_window_buffer.sv
// Directed self-checking bench for row_window_buffer with hand-computed expectations.
module tb_row_window_buffer;

  localparam int ROWS    = 3;
  localparam int DEPTH   = 70;
  localparam int PIX_IN  = 32;
  localparam int PIX_OUT = 32;
  localparam int DW      = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [3:0]           cfg_k;
  logic [2:0]           cfg_d;
  logic [1:0]           slab_num;
  logic [ROWS*2*DW-1:0] slab_in;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;

  row_window_buffer_if #(.ROWS(ROWS), .PIX_IN(PIX_IN), .PIX_OUT(PIX_OUT), .DW(DW)) bus ();

  row_window_buffer #(
    .ROWS(ROWS), .DEPTH(DEPTH), .PIX_IN(PIX_IN), .PIX_OUT(PIX_OUT), .DW(DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_k    (cfg_k),
    .cfg_d    (cfg_d),
    .slab_num (slab_num),
    .slab_in  (slab_in),
    .busy     (busy),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int p);
    return bus.win_pixels[(r*PIX_OUT+p)*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row r element j carries base + j + 0x40*r.
  task automatic drive_beat(input bit first, input bit last, input int s, input int e,
                            input logic [7:0] base);
    bus.in_valid     = 1'b1;
    bus.in_first     = first;
    bus.in_last      = last;
    bus.in_start_idx = 8'(s);
    bus.in_end_idx   = 8'(e);
    for (int r = 0; r < ROWS; r++) begin
      for (int j = 0; j < PIX_IN; j++) begin
        bus.in_pixels[(r*PIX_IN+j)*DW +: DW] = base + 8'(j) + 8'(r*64);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    cfg_k = 4'd1; cfg_d = 3'd1; slab_num = 2'd0; slab_in = '0;
    bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    bus.in_start_idx = '0; bus.in_end_idx = '0; bus.in_pixels = '0;
    bus.win_ready = 1'b0;
    tick(); tick();
    check_eq("rst_in_ready", 64'(bus.in_ready), 1);
    check_eq("rst_win_valid", 64'(bus.win_valid), 0);
    check_eq("rst_win_last", 64'(bus.win_last), 0);
    check_eq("rst_win_step", 64'(bus.win_step), 0);
    check_eq("rst_busy", 64'(busy), 0);
    check_eq("rst_pixels_zero", 64'(bus.win_pixels == '0), 1);
    reset = 1'b0;

    // Single-beat fill, cfg_k=1
    cfg_k = 4'd1; cfg_d = 3'd1; slab_num = 2'd0;
    drive_beat(1, 1, 1, 32, 8'h01);
    tick();
    bus.in_valid = 1'b0;
    check_eq("t1_win_valid", 64'(bus.win_valid), 1);
    check_eq("t1_win_last", 64'(bus.win_last), 1);
    check_eq("t1_in_ready", 64'(bus.in_ready), 0);
    check_eq("t1_p0", 64'(pix(0, 0)), 8'h00);
    check_eq("t1_p1", 64'(pix(0, 1)), 8'h01);
    check_eq("t1_p31", 64'(pix(0, 31)), 8'h1F);
    check_eq("t1_r1_p1", 64'(pix(1, 1)), 8'h41);
    bus.win_ready = 1'b1;
    tick();
    bus.win_ready = 1'b0;
    check_eq("t1_busy_after", 64'(busy), 0);
    check_eq("t1_valid_after", 64'(bus.win_valid), 0);
    check_eq("t1_hold_p1", 64'(pix(0, 1)), 8'h01);

    // Slab plus padding
    cfg_k = 4'd3; cfg_d = 3'd1; slab_num = 2'd2;
    slab_in = '0;
    slab_in[15:0]  = 16'hB2B1;
    slab_in[31:16] = 16'hC2C1;
    drive_beat(1, 1, 4, 35, 8'h10);
    tick();
    bus.in_valid = 1'b0;
    check_eq("t2_s0_p0", 64'(pix(0, 0)), 8'hB1);
    check_eq("t2_s0_p1", 64'(pix(0, 1)), 8'hB2);
    check_eq("t2_s0_p2", 64'(pix(0, 2)), 8'h00);
    check_eq("t2_s0_p3", 64'(pix(0, 3)), 8'h00);
    check_eq("t2_s0_p4", 64'(pix(0, 4)), 8'h10);
    check_eq("t2_s0_r1_p0", 64'(pix(1, 0)), 8'hC1);
    check_eq("t2_s0_step", 64'(bus.win_step), 0);
    check_eq("t2_s0_last", 64'(bus.win_last), 0);
    bus.win_ready = 1'b1;
    tick();
    check_eq("t2_s1_p0", 64'(pix(0, 0)), 8'hB2);
    check_eq("t2_s1_step", 64'(bus.win_step), 1);
    tick();
    check_eq("t2_s2_p0", 64'(pix(0, 0)), 8'h00);
    check_eq("t2_s2_p2", 64'(pix(0, 2)), 8'h10);
    check_eq("t2_s2_last", 64'(bus.win_last), 1);
    tick();
    bus.win_ready = 1'b0;
    check_eq("t2_idle", 64'(busy), 0);

    // Two-beat fill with dilation 2
    cfg_k = 4'd2; cfg_d = 3'd2; slab_num = 2'd0;
    drive_beat(1, 0, 0, 31, 8'h20);
    tick();
    check_eq("t3_fill_ready", 64'(bus.in_ready), 1);
    check_eq("t3_fill_busy", 64'(busy), 1);
    check_eq("t3_fill_novalid", 64'(bus.win_valid), 0);
    drive_beat(0, 1, 32, 63, 8'h60);
    tick();
    bus.in_valid = 1'b0;
    check_eq("t3_win_valid", 64'(bus.win_valid), 1);
    check_eq("t3_s0_p0", 64'(pix(0, 0)), 8'h20);
    check_eq("t3_s0_p31", 64'(pix(0, 31)), 8'h3F);
    bus.win_ready = 1'b1;
    tick();
    check_eq("t3_s1_p0", 64'(pix(0, 0)), 8'h22);
    check_eq("t3_s1_p29", 64'(pix(0, 29)), 8'h3F);
    check_eq("t3_s1_p30", 64'(pix(0, 30)), 8'h60);
    check_eq("t3_s1_p31", 64'(pix(0, 31)), 8'h61);
    check_eq("t3_s1_last", 64'(bus.win_last), 1);
    tick();
    bus.win_ready = 1'b0;
    check_eq("t3_idle", 64'(busy), 0);

    // Backpressure at step1, with a beat offered during WIN
    cfg_k = 4'd3; cfg_d = 3'd1;
    drive_beat(1, 1, 0, 31, 8'h50);
    tick();
    bus.in_valid = 1'b0;
    bus.win_ready = 1'b1;
    tick();
    bus.win_ready = 1'b0;
    drive_beat(1, 1, 0, 31, 8'hE0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t4_hold_step", 64'(bus.win_step), 1);
      check_eq("t4_hold_p0", 64'(pix(0, 0)), 8'h51);
      check_eq("t4_hold_valid", 64'(bus.win_valid), 1);
      check_eq("t4_in_ready", 64'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    bus.win_ready = 1'b1;
    tick();
    check_eq("t4_s2_p0", 64'(pix(0, 0)), 8'h52);
    check_eq("t4_s2_last", 64'(bus.win_last), 1);
    tick();
    bus.win_ready = 1'b0;
    check_eq("t4_idle", 64'(busy), 0);

    // Reset mid-WIN
    cfg_k = 4'd3; cfg_d = 3'd1;
    drive_beat(1, 1, 0, 31, 8'h70);
    tick();
    bus.in_valid = 1'b0;
    bus.win_ready = 1'b1;
    tick();
    bus.win_ready = 1'b0;
    check_eq("t5_pre_step", 64'(bus.win_step), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t5_win_valid", 64'(bus.win_valid), 0);
    check_eq("t5_in_ready", 64'(bus.in_ready), 1);
    check_eq("t5_pixels_zero", 64'(bus.win_pixels == '0), 1);
    check_eq("t5_step", 64'(bus.win_step), 0);
    cfg_k = 4'd1;
    drive_beat(1, 1, 0, 31, 8'h05);
    tick();
    bus.in_valid = 1'b0;
    check_eq("t5_new_valid", 64'(bus.win_valid), 1);
    check_eq("t5_new_p0", 64'(pix(0, 0)), 8'h05);
    bus.win_ready = 1'b1;
    tick();
    bus.win_ready = 1'b0;

    // Clipping: positions 60..69 observed after 14 shifts of 4
    cfg_k = 4'd15; cfg_d = 3'd4; slab_num = 2'd0;
    drive_beat(1, 0, 0, 31, 8'h30);
    tick();
    drive_beat(0, 1, 60, 80, 8'h90);
    tick();
    bus.in_valid = 1'b0;
    check_eq("t6_s0_p5", 64'(pix(0, 5)), 8'h35);
    check_eq("t6_s0_p31", 64'(pix(0, 31)), 8'h4F);
    bus.win_ready = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check_eq("t6_step", 64'(bus.win_step), 14);
    check_eq("t6_last", 64'(bus.win_last), 1);
    check_eq("t6_p3", 64'(pix(0, 3)), 8'h00);
    check_eq("t6_p4", 64'(pix(0, 4)), 8'h90);
    check_eq("t6_p13", 64'(pix(0, 13)), 8'h99);
    check_eq("t6_p14", 64'(pix(0, 14)), 8'h00);
    check_eq("t6_r2_p4", 64'(pix(2, 4)), 8'h10);
    tick();
    bus.win_ready = 1'b0;
    check_eq("t6_idle", 64'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/row_window_buffer.md
# row_window_buffer

Parametrised multi-row pixel window buffer for the convolution datapath. It collects one padded input row slice per channel-row from the line buffer in one or more chunk beats, then presents a sliding PIX_OUT-wide window to the PE array for `cfg_k` kernel-column steps. Between steps it shifts by a programmable dilation. It sits between the line-buffer read port and the PE-array pixel inputs, and generalises the fixed 3-row/70-register window with ready/valid handshakes, configurable row count, depth and dilation, and explicit step tagging.

## Interface
- `ROWS`, default 3: number of parallel row registers (kernel rows).
- `DEPTH`, default 70: pixel positions per row register.
- `PIX_IN`, default 32: pixels per input chunk beat.
- `PIX_OUT`, default 32: pixels per row presented to the PE array. Must be ≤ DEPTH.
- `DW`, default 8: pixel width in bits.
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `cfg_k`, in, 4: kernel width = number of window steps. A value of 0 is treated as 1.
- `cfg_d`, in, 3: shift per step (dilation), 1..4. A value of 0 is treated as 1.
- `slab_num`, in, 2: carried-over pixels from the previous slice, 0..2. A value of 3 is treated as 2.
- `slab_in`, in, ROWS*2*DW: carried pixels; row r occupies `[r*2*DW +: 2*DW]`, and its low byte goes to position 0.
- `in_valid`, in, 1: chunk beat valid.
- `in_ready`, out, 1: chunk beat accepted when `in_valid && in_ready`.
- `in_first`, in, 1: first beat of a row slice.
- `in_last`, in, 1: last beat of a row slice.
- `in_start_idx`, in, 8: first register position written by the beat.
- `in_end_idx`, in, 8: last register position written, inclusive.
- `in_pixels`, in, ROWS*PIX_IN*DW: chunk pixels. Element j of row r goes to position `in_start_idx+j`.
- `win_valid`, out, 1: window valid.
- `win_ready`, in, 1: the PE array consumes the window.
- `win_pixels`, out, ROWS*PIX_OUT*DW: positions 0..PIX_OUT-1 of every row register.
- `win_step`, out, 4: index of the current step, 0..cfg_k-1.
- `win_last`, out, 1: high together with `win_valid` on step cfg_k-1.
- `busy`, out, 1: state ≠ IDLE.

## Operation
- Storage is ROWS×DEPTH×DW registers, all zero on reset.
- The FSM has three states: IDLE, FILL, WIN.
- `in_ready` = 1 in IDLE and FILL, 0 in WIN.
- Config inputs are sampled on the accepted beat that has `in_first`, and held until the FSM returns to IDLE.
- On an accepted beat with `in_first`:
  - Every position not written by this beat is cleared to 0. Zeros therefore supply the west/east padding.
  - Positions 0..slab_num-1 take `slab_in`.
  - Positions in_start_idx..in_end_idx take `in_pixels`.
  - The beat's writes win over both the clear and the slab.
- On an accepted beat without `in_first`: only positions in_start_idx..in_end_idx are written. All others hold.
- Write-range clipping:
  - Positions ≥ DEPTH and element indices j ≥ PIX_IN are dropped.
  - If `in_start_idx > in_end_idx`, the beat writes nothing, but the clear and slab still apply if `in_first`.
- Beat without `in_first` accepted while in IDLE: treated as if `in_first`=1.
- State transitions:
  - IDLE → FILL on an accepted beat with `in_last`=0.
  - IDLE or FILL → WIN on an accepted beat with `in_last`=1, including a single beat that has both first and last.
- In WIN, `win_valid`=1 and `win_step` counts steps.
- On a WIN handshake:
  - If `win_step` = cfg_k-1: go to IDLE and set `win_step` to 0. Storage holds.
  - Otherwise: every row shifts down by cfg_d (position p ← p+cfg_d, positions ≥ DEPTH-cfg_d ← 0), and `win_step` increments.
- `win_ready`=0 in WIN: storage and step hold, and `win_valid` stays high.
- An `in_valid` beat arriving in WIN is not accepted and has no effect.

## Timing
- Reset values:
  - `in_ready`=1
  - `win_valid`=0
  - `win_last`=0
  - `win_step`=0
  - `busy`=0
  - `win_pixels`=0
- Outputs are decoded from registered state; there is no combinational path from `in_*` to `win_*`.
- Latency:
  - `win_valid` rises the cycle after the `in_last` beat is accepted.
  - `win_pixels` then shows the filled data.
- Throughput:
  - One chunk beat per cycle.
  - One window step per cycle when `win_ready` is held high.
  - cfg_k=3 with a single-beat fill occupies 4 cycles; the next fill can be accepted in cycle 5.
- Reset asserted mid-FILL or mid-WIN: the next cycle is IDLE with all storage zero, and the in-flight slice is discarded.

## Test plan
- **Single-beat fill, cfg_k=1.** slab_num=0, beat (first, last, start 1, end 32, row0 pixels 1..32).
  - Next cycle: win_valid=1, win_last=1.
  - Row0 position 0=0, positions 1..31=1..31.
  - After the handshake: IDLE, busy=0.
- **Slab plus padding.** slab_num=2, slab row0={0xB2,0xB1}, beat start 4, end 35, cfg_k=3, cfg_d=1.
  - Step0 row0: position0=0xB1, position1=0xB2, positions 2..3=0, position4=pixel0.
  - Step1: position0=0xB2.
  - Step2: position0=0, win_last=1.
- **Two-beat fill with dilation.** Beat A (first, start 0, end 31), beat B (last, start 32, end 63), cfg_k=2, cfg_d=2.
  - In_ready=1 for both beats; window follows B by 1 cycle.
  - Step1 position p equals step0 position p+2; positions 68..69=0.
- **Backpressure.** win_ready=0 for 5 cycles during step1 of cfg_k=3.
  - win_step stays 1, win_pixels stable, in_valid ignored.
  - Release: steps complete in 2 further handshakes.
- **Reset mid-WIN.** Assert reset at step1.
  - Next cycle: win_valid=0, in_ready=1, all win_pixels=0.
  - A new first/last beat then produces a window 1 cycle later.
- **Clipping.** start 60, end 80, PIX_IN=32.
  - Positions 60..69 written with elements 0..9; no other change; no error.
